// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helpers for the fifo block.
//   DATA_WIDTH_DEF : default word width in bits
//   DEPTH_DEF      : default number of storage entries (power of two)
//   clog2()        : pointer width for a given depth
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  // Smallest r such that 2**r >= value; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_WIDTH storage array for the fifo: one synchronous write port
// and one combinational read port (the fifo registers the read data).
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Contents are intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
// Synchronous single-clock FIFO with registered read data and registered
// full/empty flags derived from an occupancy count.
// Optional build macro: FIFO_ERR_EN adds sticky overflow/underflow outputs.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   dataIn    : write data, sampled when a write is accepted
//   enqueue   : write request (one word per cycle)
//   dequeue   : read request (one word per cycle)
//   dataOut   : registered read data, holds when no read is accepted
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : (FIFO_ERR_EN) sticky, enqueue ignored while full
//   underflow : (FIFO_ERR_EN) sticky, dequeue ignored while empty
// ---------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  enqueue,
  input  logic                  dequeue,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  full,
`ifdef FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // simultaneous write. An empty FIFO never bypasses write data to dataOut.
  assign rd_acc = dequeue && !empty_q;
  assign wr_acc = enqueue && (!full_q || rd_acc);

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (dataIn),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = ram_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
    end
  end

  assign dataOut = dout_q;
  assign full    = full_q;
  assign empty   = empty_q;

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; only reset clears them.
  always_comb begin
    ovf_d = ovf_q || (enqueue && !wr_acc);
    unf_d = unf_q || (dequeue && !rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] dataIn = '0;
  logic          enqueue = 1'b0;
  logic          dequeue = 1'b0;
  logic [DW-1:0] dataOut;
  logic          full;
  logic          empty;
`ifdef FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dataIn    (dataIn),
    .enqueue   (enqueue),
    .dequeue   (dequeue),
    .dataOut   (dataOut),
    .full      (full),
`ifdef FIFO_ERR_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words plus the last value read.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;

  always @(posedge clk or negedge rst_n) begin : model
    int  n;
    bit  rd;
    bit  wr;
    if (!rst_n) begin
      m_q.delete();
      m_dout <= '0;
      m_ovf  <= 1'b0;
      m_unf  <= 1'b0;
    end else begin
      n  = m_q.size();
      rd = dequeue && (n > 0);
      wr = enqueue && ((n < DEPTH) || rd);
      if (rd) m_dout <= m_q.pop_front();
      if (wr) m_q.push_back(dataIn);
      if (enqueue && !wr) m_ovf <= 1'b1;
      if (dequeue && !rd) m_unf <= 1'b1;
    end
  end

  // Every-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dataOut", 32'(dataOut), 32'(m_dout));
      chk("full",    32'(full),    32'(m_q.size() == DEPTH));
      chk("empty",   32'(empty),   32'(m_q.size() == 0));
`ifdef FIFO_ERR_EN
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  // One clock of stimulus; returns #1 after the rising edge.
  task automatic step(input bit e, input bit d, input logic [DW-1:0] din);
    @(negedge clk);
    enqueue = e;
    dequeue = d;
    dataIn  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst dataOut", 32'(dataOut), 32'h00);
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] held;
  int p_en;
  int p_de;

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #20;
    chk("por empty", 32'(empty), 32'd1);
    chk("por full", 32'(full), 32'd0);
    chk("por dataOut", 32'(dataOut), 32'h00);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle();

    // Write then read three words
    step(1, 0, 8'hF0);
    step(1, 0, 8'h0F);
    step(1, 0, 8'h01);
    chk("wr3 empty", 32'(empty), 32'd0);
    step(0, 1, '0);
    chk("rd1", 32'(dataOut), 32'hF0);
    step(0, 1, '0);
    chk("rd2", 32'(dataOut), 32'h0F);
    step(0, 1, '0);
    chk("rd3", 32'(dataOut), 32'h01);
    chk("rd3 empty", 32'(empty), 32'd1);
    idle();
    chk("hold dataOut", 32'(dataOut), 32'h01);

    // Fill, ignored ninth write, drain
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h10 + i));
    chk("fill full", 32'(full), 32'd1);
    step(1, 0, 8'hFF);
    chk("ovf full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      chk("drain", 32'(dataOut), 32'(8'h10 + i));
    end
    chk("drain empty", 32'(empty), 32'd1);

    // Pointer wrap
    for (int i = 0; i < 5; i++) step(1, 0, 8'(i));
    for (int i = 0; i < 5; i++) step(0, 1, '0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hA0 + i));
    chk("wrap full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      chk("wrap rd", 32'(dataOut), 32'(8'hA0 + i));
    end

    // Simultaneous access while full
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h20 + i));
    step(1, 1, 8'h55);
    chk("sim full dout", 32'(dataOut), 32'h20);
    chk("sim full flag", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 1, '0);
    chk("sim 55 last", 32'(dataOut), 32'h55);

    // Simultaneous access while empty: no bypass
    held = dataOut;
    step(1, 1, 8'h33);
    chk("sim empty dout", 32'(dataOut), 32'(held));
    chk("sim empty flag", 32'(empty), 32'd0);
    step(0, 1, '0);
    chk("sim 33", 32'(dataOut), 32'h33);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i));
    pulse_reset();
    step(0, 1, '0);
    chk("post-rst dout", 32'(dataOut), 32'h00);
    chk("post-rst empty", 32'(empty), 32'd1);
`ifdef FIFO_ERR_EN
    chk("underflow set", 32'(underflow), 32'd1);
    chk("overflow clr", 32'(overflow), 32'd0);
`endif

    // Randomised traffic with varying fill pressure
    for (int blk = 0; blk < 20; blk++) begin
      p_en = $urandom_range(10, 90);
      p_de = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < p_en, $urandom_range(0, 99) < p_de, 8'($urandom));
      end
      if (blk == 9) begin
        pulse_reset();
      end
    end

    idle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width in bits of each stored word.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of storage entries; legal values are powers of two, 2..256.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port dataIn, input, DATA_WIDTH bits, the write data sampled when enqueue is accepted.
REQ-006 The block SHALL have port enqueue, input, 1 bit, the write request, level-sensitive, one word per cycle.
REQ-007 The block SHALL have port dequeue, input, 1 bit, the read request, level-sensitive, one word per cycle.
REQ-008 The block SHALL have port dataOut, output, DATA_WIDTH bits, registered read data.
REQ-009 The block SHALL have port full, output, 1 bit, high when the entry count equals DEPTH.
REQ-010 The block SHALL have port empty, output, 1 bit, high when the entry count equals 0.

Function
REQ-011 A write SHALL be accepted on a rising edge when enqueue=1 and (full=0 or a read is accepted in the same cycle): dataIn is stored at the write pointer, and the write pointer advances modulo DEPTH.
REQ-012 A read SHALL be accepted on a rising edge when dequeue=1 and empty=0: the oldest word is loaded into dataOut at that edge, which is one-cycle latency, and the read pointer advances modulo DEPTH.
REQ-013 dataOut SHALL hold its last value in every cycle in which no read is accepted.
REQ-014 Ordering SHALL be strictly first-in first-out; pointers SHALL wrap from DEPTH-1 to 0 without loss.
REQ-015 An enqueue while full with no dequeue SHALL be ignored, leaving storage, pointers and flags unchanged.
REQ-016 A dequeue while empty SHALL be ignored, leaving dataOut unchanged.
REQ-017 If enqueue and dequeue are both asserted while empty, only the write SHALL take effect (no bypass), and empty SHALL deassert next cycle.
REQ-018 If enqueue and dequeue are both asserted while full, both SHALL take effect, and full SHALL remain 1.
REQ-019 If enqueue and dequeue are both asserted with 0<count<DEPTH, both SHALL take effect and the count is unchanged.
REQ-020 full and empty SHALL be registered, derived from an occupancy count of width log2(DEPTH)+1 bits, and valid in the same cycle as the state they describe.

Reset
REQ-021 On rst_n=0 the block SHALL immediately, regardless of clk, clear the pointers and count to 0, set dataOut to 0, set empty to 1 and set full to 0.
REQ-022 Storage contents need not be cleared; a reset mid-operation SHALL discard all stored words.
REQ-023 Operation SHALL resume on the first rising edge after rst_n returns to 1.

Configuration
REQ-024 The macro FIFO_ERR_EN SHALL enable two extra outputs, overflow and underflow, each 1 bit, sticky, and cleared only by reset.
REQ-025 With FIFO_ERR_EN defined, overflow SHALL set on an ignored enqueue under REQ-015, and underflow SHALL set on an ignored dequeue under REQ-016.
REQ-026 Without FIFO_ERR_EN, those ports and their logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-027 The package fifo_pkg SHALL hold the DATA_WIDTH and DEPTH defaults and a pointer-width function clog2.
REQ-028 Storage SHALL be a sub-module fifo_ram: a DEPTH x DATA_WIDTH array with one synchronous write port and one read port; pointer, count and flag logic SHALL stay in fifo.

Verification
REQ-029 Reset: rst_n=0 then 1 -> empty=1, full=0, dataOut=8'h00.
REQ-030 Write then read: enqueue 8'hF0, 8'h0F, 8'h01 on consecutive cycles, then dequeue for 3 cycles -> dataOut is F0, 0F, 01 on the respective following edges; empty=1 after the third read.
REQ-031 Fill: 8 writes of 8'h10..8'h17 -> full=1 after the 8th write; a 9th write of 8'hFF is ignored; 8 reads return 10..17.
REQ-032 Wrap: 5 writes, 5 reads, then 8 writes of 8'hA0..8'hA7 and 8 reads -> A0..A7 in order, with no flag glitches.
REQ-033 Simultaneous access: when full, enqueue 8'h55 with dequeue -> oldest word out, full stays 1, and 8'h55 is later read last; when empty, enqueue 8'h33 with dequeue -> dataOut unchanged, then empty=0.
REQ-034 Reset mid-operation with FIFO_ERR_EN defined: after 3 writes, pulse rst_n -> empty=1; a dequeue then sets underflow=1.
